instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Decoupling FIFO between instr_fetcher (upstream producer of fetched_instr_t) and the decode stage (downstream consumer).
- Absorbs decoder back-pressure so the fetcher keeps issuing icache requests.
- i_ready is registered, which cuts the fetcher-ready-to-icache-request path.
- Discards all queued instructions on a backend redirect (flush).

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- i_flush  input  1  backend redirect; asserted in the same cycle the redirect PC is presented to instr_fetcher.
- i_valid  input  1  fetcher has an instruction.
- i_ready  output  1  queue can accept an instruction.
- i_fetched_instr  input  $bits(fetched_instr_t)  instruction from the fetcher.
- o_valid  output  1  instruction available to decode.
- o_ready  input  1  decode accepts.
- o_fetched_instr  output  $bits(fetched_instr_t)  instruction to decode.
- o_count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage and pointers
  - Storage: DEPTH x fetched_instr_t array; payload is not reset.
  - rd_ptr and wr_ptr are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Index = ptr[$clog2(DEPTH)-1:0].
  - count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
  - full when count == DEPTH; empty when count == 0.
- Reset values: rd_ptr = wr_ptr = 0, o_count = 0, o_valid = 0, i_ready = 1.
- i_ready
  - Driven from a flop: i_ready = !full.
  - Must not depend combinationally on i_valid, o_ready or i_flush. The fetcher gates its icache request with ready, so any such dependency creates a combinational loop.
- Handshakes
  - push = i_valid && i_ready && !i_flush.
  - pop = o_valid && o_ready.
  - i_fetched_instr is captured only on push.
  - o_fetched_instr is stable while o_valid && !o_ready. Once o_valid is asserted it stays high until pop or flush.
- Output
  - o_valid = !empty && !i_flush.
  - o_fetched_instr = mem[rd_ptr index].
  - Latency input to output: 1 cycle (a push at cycle N is visible at N+1).
- Simultaneous push and pop
  - Not full: both pointers advance and count is unchanged.
  - Full: i_ready = 0, so no push is possible; a pop frees one slot and i_ready rises the next cycle.
- Wrap-around: pointers increment freely. Entry DEPTH-1 is followed by entry 0 with the wrap bit toggled; full/empty are distinguished by the wrap bit.
- Flush
  - On i_flush = 1: next cycle rd_ptr <= wr_ptr and count = 0.
  - Any input beat offered in the flush cycle is dropped; it is the pre-redirect instruction.
  - o_valid = 0 during the flush cycle.
  - The first post-redirect instruction (carrying a non-prefetch if_reason) is accepted from the next cycle.
  - Flush has priority over push and pop.
- Reset mid-operation: rst takes effect at the next clock edge regardless of the handshakes in flight. Queued contents are abandoned and the state returns to the reset values.
- Assertions (simulation only)
  - No push when full.
  - count <= DEPTH.
  - o_fetched_instr stable under o_valid && !o_ready.

Optional Feature:
- Macro: INSTR_QUEUE_BYPASS_EN.
- Defined:
  - When empty and i_valid && !i_flush: o_valid = 1 and o_fetched_instr = i_fetched_instr combinationally, giving 0-cycle latency.
  - If o_ready is also high, the instruction passes through without being written and the pointers are unchanged.
  - If o_ready is low, it is written as a normal push.
  - i_ready remains registered (unchanged rule).
  - Data is still stable under stall: a stalled bypass beat is then read from mem[rd_ptr].
- Undefined: no bypass; 1-cycle minimum latency as specified above.

Test Plan:
- Reset, then push 3 instructions with pc 0x100/0x104/0x108, o_ready = 1 -> emerge in order, each 1 cycle after push; o_count peaks at 1; i_ready stays 1.
- o_ready = 0, push 4 instructions with pc 0x0/0x4/0x8/0xC (DEPTH = 4) -> o_count = 4; i_ready = 0 from the cycle after the 4th push; the 5th i_valid is ignored; o_fetched_instr.pc stays 0x0.
- From full, hold o_ready = 1 and i_valid = 1 for 12 cycles -> pointer wrap occurs; outputs stay strictly in order with no duplicate or lost pc; o_count stays at 3–4.
- With 3 entries queued, assert i_flush together with an i_valid beat of pc 0x200 -> o_valid = 0 in that cycle; next cycle o_count = 0 and 0x200 is not emitted; a subsequent push of 0x300 is emitted first.
- Assert rst while 2 entries are queued and o_ready = 1 -> next cycle o_valid = 0, o_count = 0, i_ready = 1.
- INSTR_QUEUE_BYPASS_EN defined, empty queue, i_valid with pc 0x40 and o_ready = 1 -> o_valid = 1 and pc 0x40 in the same cycle; o_count stays 0. Repeat with o_ready = 0 -> o_count = 1 next cycle and 0x40 held.

Source files
------------

// File: rtl/instr_queue.sv
// instr_queue: decoupling FIFO between instr_fetcher and decode; optional 0-cycle bypass via INSTR_QUEUE_BYPASS_EN
package instr_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  if_reason;
    } fetched_instr_t;
endpackage

module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  fetched_instr_t         i_fetched_instr,
    output logic                   o_valid,
    input  logic                   o_ready,
    output fetched_instr_t         o_fetched_instr,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetched_instr_t r_mem [DEPTH];
    logic [AW:0] r_rd_ptr, r_wr_ptr;
    logic        r_ready;
    logic [AW:0] w_count, w_rd_nxt, w_wr_nxt;
    logic        w_empty, w_full, w_byp, w_push, w_pop, w_write, w_pop_mem;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = w_count == '0;
    assign w_full  = w_count == FULL;
`ifdef INSTR_QUEUE_BYPASS_EN
    assign w_byp = w_empty && i_valid && !i_flush;
`else
    assign w_byp = 1'b0;
`endif

    // handshakes, output mux and next pointer values; flush overrides push and pop
    always_comb begin
        o_valid         = (!w_empty || w_byp) && !i_flush;
        o_fetched_instr = w_byp ? i_fetched_instr : r_mem[r_rd_ptr[AW-1:0]];
        w_push          = i_valid && r_ready && !i_flush;
        w_pop           = o_valid && o_ready;
        w_write         = w_push && !(w_byp && o_ready);
        w_pop_mem       = w_pop && !w_empty;
        w_wr_nxt        = r_wr_ptr + (AW+1)'(w_write);
        w_rd_nxt        = i_flush ? r_wr_ptr : r_rd_ptr + (AW+1)'(w_pop_mem);
    end

    assign i_ready = r_ready;
    assign o_count = w_count;

    // pointers and registered ready (computed from next occupancy so it never sees this cycle's handshakes)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= w_wr_nxt;
            r_ready  <= (w_wr_nxt - w_rd_nxt) != FULL;
        end
    end

    // payload storage, written only on a push that is not passed straight through
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr[AW-1:0]] <= i_fetched_instr;
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));
    a_count_max:    assert property (@(posedge clk) disable iff (rst) w_count <= FULL);
    a_stable:       assert property (@(posedge clk) disable iff (rst)
                        (o_valid && !o_ready) |=> $stable(o_fetched_instr));
`endif
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: table-driven directed check of instr_queue (DEPTH = 4)
module tb_instr_queue;
    import instr_queue_pkg::*;

    typedef struct {
        logic        rst, flush, valid;
        logic [31:0] pc;
        logic        ordy, chk, ev, eir;
        logic [2:0]  cnt;
        logic [31:0] epc;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0, i_flush = 1'b0, i_valid = 1'b0, o_ready = 1'b0;
    logic           i_ready, o_valid;
    fetched_instr_t i_fetched_instr = '0, o_fetched_instr;
    logic [2:0]     o_count;
    int             n_cmp = 0, n_err = 0;

    instr_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .i_ready(i_ready),
        .i_fetched_instr(i_fetched_instr), .o_valid(o_valid), .o_ready(o_ready),
        .o_fetched_instr(o_fetched_instr), .o_count(o_count)
    );

    always #5 clk = ~clk;

    function automatic fetched_instr_t mkp(input logic [31:0] pc);
        mkp.pc = pc;
        mkp.instr = ~pc;
        mkp.if_reason = pc[3:2];
    endfunction

    // fields: rst flush valid pc ordy | chk ev epc eir cnt (outputs observed before the edge)
    function automatic vec_t mk(input logic r, f, v, input logic [31:0] pc, input logic ordy,
                                input logic chk, ev, input logic [31:0] epc, input logic eir,
                                input logic [2:0] cnt);
        mk.rst = r; mk.flush = f; mk.valid = v; mk.pc = pc; mk.ordy = ordy;
        mk.chk = chk; mk.ev = ev; mk.epc = epc; mk.eir = eir; mk.cnt = cnt;
    endfunction

    task automatic cmp(input string name, input int row, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int row);
        @(negedge clk);
        rst = v.rst; i_flush = v.flush; i_valid = v.valid; o_ready = v.ordy;
        i_fetched_instr = mkp(v.pc);
        #1;
        if (v.chk) begin
            cmp("o_valid", row, 66'(o_valid), 66'(v.ev));
            if (v.ev) cmp("o_fetched_instr", row, o_fetched_instr, mkp(v.epc));
            cmp("i_ready", row, 66'(i_ready), 66'(v.eir));
            cmp("o_count", row, 66'(o_count), 66'(v.cnt));
        end
    endtask

    vec_t tbl [32];

    initial begin
        tbl[0]  = mk(1,0,0,32'h0,  0, 0,0,32'h0,  1,0);
        tbl[1]  = mk(0,0,1,32'h100,1, 1,0,32'h0,  1,0);
        tbl[2]  = mk(0,0,1,32'h104,1, 1,1,32'h100,1,1);
        tbl[3]  = mk(0,0,1,32'h108,1, 1,1,32'h104,1,1);
        tbl[4]  = mk(0,0,0,32'h0,  1, 1,1,32'h108,1,1);
        tbl[5]  = mk(0,0,0,32'h0,  1, 1,0,32'h0,  1,0);
        tbl[6]  = mk(0,0,1,32'h0,  0, 1,0,32'h0,  1,0);
        tbl[7]  = mk(0,0,1,32'h4,  0, 1,1,32'h0,  1,1);
        tbl[8]  = mk(0,0,1,32'h8,  0, 1,1,32'h0,  1,2);
        tbl[9]  = mk(0,0,1,32'hC,  0, 1,1,32'h0,  1,3);
        tbl[10] = mk(0,0,1,32'h10, 0, 1,1,32'h0,  0,4);
        tbl[11] = mk(0,0,1,32'h10, 0, 1,1,32'h0,  0,4);
        tbl[12] = mk(0,0,1,32'h10, 1, 1,1,32'h0,  0,4);
        tbl[13] = mk(0,0,1,32'h10, 1, 1,1,32'h4,  1,3);
        tbl[14] = mk(0,0,1,32'h14, 1, 1,1,32'h8,  1,3);
        tbl[15] = mk(0,0,1,32'h18, 1, 1,1,32'hC,  1,3);
        tbl[16] = mk(0,0,1,32'h1C, 1, 1,1,32'h10, 1,3);
        tbl[17] = mk(0,0,1,32'h20, 1, 1,1,32'h14, 1,3);
        tbl[18] = mk(0,0,1,32'h24, 1, 1,1,32'h18, 1,3);
        tbl[19] = mk(0,0,1,32'h28, 1, 1,1,32'h1C, 1,3);
        tbl[20] = mk(0,0,1,32'h2C, 1, 1,1,32'h20, 1,3);
        tbl[21] = mk(0,0,1,32'h30, 1, 1,1,32'h24, 1,3);
        tbl[22] = mk(0,0,1,32'h34, 1, 1,1,32'h28, 1,3);
        tbl[23] = mk(0,0,1,32'h38, 1, 1,1,32'h2C, 1,3);
        tbl[24] = mk(0,1,1,32'h200,0, 1,0,32'h0,  1,3);
        tbl[25] = mk(0,0,0,32'h0,  0, 1,0,32'h0,  1,0);
        tbl[26] = mk(0,0,1,32'h300,0, 1,0,32'h0,  1,0);
        tbl[27] = mk(0,0,1,32'h304,1, 1,1,32'h300,1,1);
        tbl[28] = mk(0,0,0,32'h0,  0, 1,1,32'h304,1,1);
        tbl[29] = mk(0,0,1,32'h308,0, 1,1,32'h304,1,1);
        tbl[30] = mk(1,0,1,32'h30C,1, 1,1,32'h304,1,2);
        tbl[31] = mk(0,0,0,32'h0,  1, 1,0,32'h0,  1,0);
`ifndef INSTR_QUEUE_BYPASS_EN
        for (int i = 0; i < 32; i++) step(tbl[i], i);
        // fill to full while stalled, then flush together with a pop request: ready must recover
        for (int i = 0; i < 4; i++) step(mk(0,0,1,32'h500 + 32'(4*i),0, 0,0,32'h0,1,0), 100 + i);
        step(mk(0,0,0,32'h0,  0, 1,1,32'h500,0,4), 104);
        step(mk(0,1,1,32'h600,1, 1,0,32'h0,  0,4), 105);
        step(mk(0,0,1,32'h700,0, 1,0,32'h0,  1,0), 106);
        step(mk(0,0,0,32'h0,  0, 1,1,32'h700,1,1), 107);
`else
        step(tbl[0], 0);
        step(mk(0,0,1,32'h40,1, 1,1,32'h40,1,0), 200);
        step(mk(0,0,0,32'h0, 1, 1,0,32'h0, 1,0), 201);
        step(mk(0,0,1,32'h40,0, 1,1,32'h40,1,0), 202);
        step(mk(0,0,0,32'h0, 0, 1,1,32'h40,1,1), 203);
        step(mk(0,0,0,32'h0, 1, 1,1,32'h40,1,1), 204);
        step(mk(0,0,0,32'h0, 1, 1,0,32'h0, 1,0), 205);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
